// File: rtl/myo_control_pkg.sv
// Shared definitions for the myo control board sweep logic: FSM states,
// PWM word width and the minimum accepted sweep period.
package myo_control_pkg;

  localparam int PWM_W      = 16;
  localparam int PERIOD_MIN = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_GAP,
    ST_OFFER
  } sweep_state_t;

  function automatic logic [31:0] clamp_period(input logic [31:0] period);
    return (period < 32'(PERIOD_MIN)) ? 32'(PERIOD_MIN) : period;
  endfunction

endpackage

// File: rtl/pid_sweep_scheduler_if.sv
// PWM frame handshake between the sweep scheduler (master) and the SPI
// frame builder (slave).
interface pid_sweep_scheduler_if
  import myo_control_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6
) ();

  logic [PWM_W*NUMBER_OF_MOTORS-1:0] pwm_out;
  logic                              frame_valid;
  logic                              frame_ready;

  modport master (output pwm_out, output frame_valid, input frame_ready);
  modport slave  (input pwm_out, input frame_valid, output frame_ready);

endinterface

// File: rtl/pid_period_timer.sv
// Free-running sweep period down-counter: loads the clamped period minus one,
// emits a one-cycle tick at zero and reloads from the current period input.
module pid_period_timer
  import myo_control_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i_update_period,
  output logic        o_tick
);

  logic        r_loaded;
  logic [31:0] r_count;
  logic [31:0] w_reload;

  assign w_reload = clamp_period(i_update_period) - 32'd1;

  // First cycle out of reset only loads; ticks start one full period later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_loaded <= 1'b0;
      r_count  <= '0;
    end else if (!r_loaded || r_count == 32'd0) begin
      r_loaded <= 1'b1;
      r_count  <= w_reload;
    end else begin
      r_count <= r_count - 32'd1;
    end
  end

  assign o_tick = r_loaded && (r_count == 32'd0);

endmodule

// File: rtl/pid_sweep_scheduler.sv
// Staggered PID update strobes and PWM frame snapshot for one myo board.
// Optional PID_SWEEP_OVERRUN_EN adds a saturating count of dropped ticks.
module pid_sweep_scheduler
  import myo_control_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int STROBE_WIDTH     = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [31:0]                       update_period,
  input  logic [NUMBER_OF_MOTORS-1:0]       motor_enable,
  input  logic [PWM_W*NUMBER_OF_MOTORS-1:0] pwm_in,
  output logic [NUMBER_OF_MOTORS-1:0]       update_controller,
  pid_sweep_scheduler_if.master             frame_if,
  output logic                              busy,
  output logic [15:0]                       sweep_count
`ifdef PID_SWEEP_OVERRUN_EN
  ,
  output logic [15:0]                       overrun_count
`endif
);

  localparam int IDX_W = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;
  localparam int CNT_W = (STROBE_WIDTH > 1) ? $clog2(STROBE_WIDTH) : 1;

  sweep_state_t                r_state;
  logic [IDX_W-1:0]            r_idx;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_slot_en;
  logic [NUMBER_OF_MOTORS-1:0] r_update;
  logic [PWM_W-1:0]            r_pwm [NUMBER_OF_MOTORS];
  logic                        r_valid;
  logic [15:0]                 r_sweep;

  logic                        w_tick;
  logic                        w_last;
  logic                        w_slot_done;
  logic [IDX_W-1:0]            w_next_idx;
  logic [PWM_W-1:0]            w_pwm_in [NUMBER_OF_MOTORS];

  pid_period_timer u_timer (
    .clock           (clock),
    .reset           (reset),
    .i_update_period (update_period),
    .o_tick          (w_tick)
  );

  generate
    for (genvar gi = 0; gi < NUMBER_OF_MOTORS; gi++) begin : g_slot
      assign w_pwm_in[gi]                          = pwm_in[PWM_W*gi +: PWM_W];
      assign frame_if.pwm_out[PWM_W*gi +: PWM_W] = r_pwm[gi];
    end
  endgenerate

  assign w_next_idx  = r_idx + IDX_W'(1);
  assign w_last      = (r_idx == IDX_W'(NUMBER_OF_MOTORS - 1));
  assign w_slot_done = (r_state == ST_GAP) || ((r_state == ST_STROBE) && !r_slot_en);

  // Strobes are registered, so each slot's enable bit is taken on the edge
  // that opens the slot and held in r_slot_en for the slot's duration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_slot_en <= 1'b0;
      r_update  <= '0;
      r_valid   <= 1'b0;
      r_sweep   <= '0;
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) r_pwm[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_tick && enable) begin
            r_idx     <= '0;
            r_cnt     <= '0;
            r_slot_en <= motor_enable[0];
            r_update  <= motor_enable[0] ? NUMBER_OF_MOTORS'(1) : '0;
            r_state   <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (!r_slot_en) begin
            r_pwm[r_idx] <= '0;
          end else if (r_cnt == CNT_W'(STROBE_WIDTH - 1)) begin
            r_update <= '0;
            r_state  <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          r_pwm[r_idx] <= w_pwm_in[r_idx];
        end
        ST_OFFER: begin
          if (frame_if.frame_ready) begin
            r_valid <= 1'b0;
            r_sweep <= r_sweep + 16'd1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_slot_done) begin
        if (w_last) begin
          r_valid <= 1'b1;
          r_state <= ST_OFFER;
        end else begin
          r_idx     <= w_next_idx;
          r_cnt     <= '0;
          r_slot_en <= motor_enable[w_next_idx];
          r_update  <= motor_enable[w_next_idx] ? (NUMBER_OF_MOTORS'(1) << w_next_idx) : '0;
          r_state   <= ST_STROBE;
        end
      end
    end
  end

  assign update_controller    = r_update;
  assign frame_if.frame_valid = r_valid;
  assign busy                 = (r_state != ST_IDLE);
  assign sweep_count          = r_sweep;

`ifdef PID_SWEEP_OVERRUN_EN
  logic [15:0] r_overrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overrun <= '0;
    end else if (w_tick && enable && (r_state != ST_IDLE) && (r_overrun != 16'hFFFF)) begin
      r_overrun <= r_overrun + 16'd1;
    end
  end

  assign overrun_count = r_overrun;
`endif

endmodule
